output_port_scheduler: RTL and testbench

OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

---
 rtl/output_port_scheduler_pkg.sv | 13 +
 rtl/output_port_scheduler_rr_arbiter.sv | 25 ++
 rtl/output_port_scheduler.sv | 106 ++++++++++
 tb/tb_output_port_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_port_scheduler_pkg.sv
// rtl/output_port_scheduler_pkg.sv - shared flit encodings and scheduler state type
package output_port_scheduler_pkg;

  localparam logic [2:0] FLIT_HEADER  = 3'b001;
  localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0] FLIT_TAIL    = 3'b100;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/output_port_scheduler_rr_arbiter.sv
// rtl/output_port_scheduler_rr_arbiter.sv - combinational round-robin pick, last served lowest priority
module rr_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int IW      = 3
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [IW-1:0]      last_served,
  output logic [NUM_REQ-1:0] grant
);

  logic [IW-1:0] idx;

  // Walk from the lowest priority upward so the last hit (offset 1) wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_served) + k) % NUM_REQ);
      if (request[idx]) begin
        grant = NUM_REQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/output_port_scheduler.sv
// rtl/output_port_scheduler.sv - credit-based packet scheduler for one router output port
module output_port_scheduler
  import output_port_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] flit_type,
  input  logic                 credit_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   rd_en,
  output logic                 out_valid,
  output logic                 idle,
  output logic                 proto_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  sched_state_e          state;
  logic [IW-1:0]         last_served;
  logic [IW-1:0]         gidx;
  logic [CW-1:0]         credit;
  logic                  first_flit;
  logic [NUM_REQ-1:0]    hdr_mask;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [2:0]            g_type;
  logic                  xfer;

  always_comb begin
    hdr_mask = '0;
    g_type   = '0;
    gidx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hdr_mask[i] = (flit_type[3*i +: 3] == FLIT_HEADER);
      if (grant[i]) begin
        g_type = flit_type[3*i +: 3];
        gidx   = IW'(i);
      end
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .request     (req & hdr_mask),
    .last_served (last_served),
    .grant       (arb_grant)
  );

  assign xfer      = (state == ST_ACTIVE) && |(req & grant) && (credit != '0);
  assign rd_en     = xfer ? grant : '0;
  assign out_valid = xfer;
  assign idle      = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      last_served <= IW'(NUM_REQ - 1);
      credit      <= CW'(CREDITS);
      first_flit  <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      case ({xfer, credit_in})
        2'b10: credit <= credit - CW'(1);
        2'b01: begin
          if (credit == CW'(CREDITS)) proto_err <= 1'b1;
          else                        credit    <= credit + CW'(1);
        end
        default: ;
      endcase

      case (state)
        ST_IDLE: begin
          if (|arb_grant) begin
            grant      <= arb_grant;
            first_flit <= 1'b1;
            state      <= ST_ACTIVE;
          end else if (|req) begin
            proto_err  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          // Only the packet's opening flit may be a HEADER.
          if (xfer) begin
            first_flit <= 1'b0;
            if (g_type == FLIT_TAIL) begin
              grant       <= '0;
              last_served <= gidx;
              state       <= ST_IDLE;
            end else if (g_type == FLIT_HEADER && !first_flit) begin
              proto_err   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_scheduler.sv
// tb/tb_output_port_scheduler.sv - directed and randomized checks against a packet-level scheduler model
module tb_output_port_scheduler;
  import output_port_scheduler_pkg::*;

  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]   i_req [2];
  logic [3*N-1:0] i_ft  [2];
  logic           i_cin [2];

  logic [N-1:0] g0, g1, r0, r1;
  logic         v0, v1, id0, id1, e0, e1;
  logic [N-1:0] o_gnt [2];
  logic [N-1:0] o_rd  [2];
  logic         o_ov  [2];
  logic         o_idle[2];
  logic         o_err [2];
  int           obs_cred [2];

  always #5 clk = ~clk;

  output_port_scheduler #(.NUM_REQ(N), .CREDITS(4)) dut0 (
    .clk(clk), .rst(rst), .req(i_req[0]), .flit_type(i_ft[0]), .credit_in(i_cin[0]),
    .grant(g0), .rd_en(r0), .out_valid(v0), .idle(id0), .proto_err(e0)
  );

  output_port_scheduler #(.NUM_REQ(N), .CREDITS(2)) dut1 (
    .clk(clk), .rst(rst), .req(i_req[1]), .flit_type(i_ft[1]), .credit_in(i_cin[1]),
    .grant(g1), .rd_en(r1), .out_valid(v1), .idle(id1), .proto_err(e1)
  );

  assign o_gnt[0] = g0;  assign o_gnt[1] = g1;
  assign o_rd[0]  = r0;  assign o_rd[1]  = r1;
  assign o_ov[0]  = v0;  assign o_ov[1]  = v1;
  assign o_idle[0] = id0; assign o_idle[1] = id1;
  assign o_err[0] = e0;  assign o_err[1] = e1;
  assign obs_cred[0] = int'(dut0.credit);
  assign obs_cred[1] = int'(dut1.credit);

  int checks = 0;
  int errors = 0;

  // Reference model: owner is the input holding the output, -1 when free.
  int  m_owner [2];
  int  m_last  [2];
  int  m_cred  [2];
  bit  m_err   [2];
  bit  m_first [2];

  logic [2:0] srcq [2][N][$];
  bit             raw_mode = 1'b0;
  logic [N-1:0]   raw_req = '0;
  logic [3*N-1:0] raw_ft = '0;
  bit             rst_next = 1'b0;
  bit             cin_req [2];
  bit             auto_cin[2];
  int             pops [2][N];
  logic [N-1:0]   order [2][$];
  logic [N-1:0]   prev_gnt [2];

  function automatic int cmax(int d);
    return (d == 0) ? 4 : 2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(int d);
    m_owner[d] = -1;
    m_last[d]  = N - 1;
    m_cred[d]  = cmax(d);
    m_err[d]   = 1'b0;
    m_first[d] = 1'b0;
  endtask

  function automatic logic [2:0] head_type(int d, int i);
    return i_ft[d][3*i +: 3];
  endfunction

  task automatic model_cycle(int d);
    logic [N-1:0] eg;
    bit           xfer;
    int           found, idx, own;
    logic [2:0]   t;
    string        p;
    p = $sformatf("d%0d_", d);
    if (!rst) model_reset(d);
    own  = m_owner[d];
    eg   = (own < 0) ? '0 : (N'(1) << own);
    xfer = rst && (own >= 0) && i_req[d][own] && (m_cred[d] > 0);
    check_eq({p, "grant"},     o_gnt[d],  eg);
    check_eq({p, "rd_en"},     o_rd[d],   xfer ? eg : '0);
    check_eq({p, "out_valid"}, o_ov[d],   xfer);
    check_eq({p, "idle"},      o_idle[d], own < 0);
    check_eq({p, "proto_err"}, o_err[d],  m_err[d]);
    check_eq({p, "credit"},    obs_cred[d], m_cred[d]);
    if (!rst) return;
    if (own < 0) begin
      found = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last[d] + k) % N;
        if (found < 0 && i_req[d][idx] && head_type(d, idx) == FLIT_HEADER) found = idx;
      end
      if (found >= 0) begin
        m_owner[d] = found;
        m_first[d] = 1'b1;
      end else if (|i_req[d]) begin
        m_err[d] = 1'b1;
      end
    end else if (xfer) begin
      t = head_type(d, own);
      if (t == FLIT_TAIL) begin
        m_last[d]  = own;
        m_owner[d] = -1;
      end else if (t == FLIT_HEADER && !m_first[d]) begin
        m_err[d] = 1'b1;
      end
      m_first[d] = 1'b0;
      if (!raw_mode && srcq[d][own].size() > 0) void'(srcq[d][own].pop_front());
    end
    if (xfer && !i_cin[d]) m_cred[d]--;
    else if (!xfer && i_cin[d]) begin
      if (m_cred[d] == cmax(d)) m_err[d] = 1'b1;
      else                      m_cred[d]++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst = rst_next;
    for (int d = 0; d < 2; d++) begin
      if (raw_mode) begin
        i_req[d] = raw_req;
        i_ft[d]  = raw_ft;
      end else begin
        for (int i = 0; i < N; i++) begin
          i_req[d][i]      = (srcq[d][i].size() > 0);
          i_ft[d][3*i +: 3] = (srcq[d][i].size() > 0) ? srcq[d][i][0] : 3'b000;
        end
      end
      i_cin[d] = cin_req[d] | (auto_cin[d] && m_cred[d] < cmax(d));
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) if (o_rd[d][i]) pops[d][i]++;
      if (prev_gnt[d] == '0 && o_gnt[d] != '0) order[d].push_back(o_gnt[d]);
      prev_gnt[d] = o_gnt[d];
      model_cycle(d);
      cin_req[d] = 1'b0;
    end
  endtask

  task automatic push_flit(int i, logic [2:0] t);
    for (int d = 0; d < 2; d++) srcq[d][i].push_back(t);
  endtask

  task automatic push_pkt(int i, int npay);
    push_flit(i, FLIT_HEADER);
    for (int k = 0; k < npay; k++) push_flit(i, FLIT_PAYLOAD);
    push_flit(i, FLIT_TAIL);
  endtask

  task automatic clear_log();
    for (int d = 0; d < 2; d++) begin
      order[d].delete();
      for (int i = 0; i < N; i++) pops[d][i] = 0;
    end
  endtask

  function automatic bit all_drained();
    for (int d = 0; d < 2; d++) begin
      if (m_owner[d] >= 0) return 1'b0;
      for (int i = 0; i < N; i++) if (srcq[d][i].size() > 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic run_drain(input string tag, int budget);
    int n = 0;
    while (!all_drained() && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_drained"}, all_drained(), 1'b1);
  endtask

  task automatic do_reset();
    rst_next = 1'b0;
    step();
    for (int d = 0; d < 2; d++) for (int i = 0; i < N; i++) srcq[d][i].delete();
    step();
    rst_next = 1'b1;
    step();
    clear_log();
  endtask

  function automatic logic [N-1:0] ord_at(int d, int k);
    return (order[d].size() > k) ? order[d][k] : '0;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      i_req[d] = '0; i_ft[d] = '0; i_cin[d] = 1'b0;
      cin_req[d] = 1'b0; auto_cin[d] = 1'b0; prev_gnt[d] = '0;
      model_reset(d);
    end
    clear_log();
    repeat (2) step();
    do_reset();

    // Single packet on L; dut1 (2 credits) stalls after two flits
    push_pkt(0, 2);
    repeat (6) step();
    check_eq("s1_pops_l", pops[0][0], 4);
    check_eq("s1_credit_end", obs_cred[0], 0);
    check_eq("s1_idle_after_tail", o_idle[0], 1'b1);
    check_eq("s1_first_grant", ord_at(0, 0), 5'b00001);
    check_eq("stall_pops", pops[1][0], 2);
    cin_req[1] = 1'b1;
    step();
    repeat (3) step();
    check_eq("stall_one_release", pops[1][0], 3);
    cin_req[1] = 1'b1;
    step();
    cin_req[1] = 1'b1;
    step();
    step();
    check_eq("stall_cred_hold", obs_cred[1], 1);
    check_eq("stall_pops_done", pops[1][0], 4);

    // Contention L, N, E from reset, then fairness after N served
    do_reset();
    auto_cin[0] = 1'b1; auto_cin[1] = 1'b1;
    push_pkt(0, 0); push_pkt(1, 0); push_pkt(2, 0);
    run_drain("contend", 60);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("contend_d%0d_n", d), order[d].size(), 3);
      check_eq($sformatf("contend_d%0d_g0", d), ord_at(d, 0), 5'b00001);
      check_eq($sformatf("contend_d%0d_g1", d), ord_at(d, 1), 5'b00010);
      check_eq($sformatf("contend_d%0d_g2", d), ord_at(d, 2), 5'b00100);
    end
    clear_log();
    push_pkt(1, 1);
    run_drain("fair_a", 30);
    push_pkt(0, 0); push_pkt(1, 0);
    run_drain("fair_b", 30);
    check_eq("fair_g0", ord_at(0, 0), 5'b00010);
    check_eq("fair_g1", ord_at(0, 1), 5'b00001);
    check_eq("fair_g2", ord_at(0, 2), 5'b00010);

    // Protocol errors: stray PAYLOAD, credit overflow, HEADER mid-packet
    do_reset();
    auto_cin[0] = 1'b0; auto_cin[1] = 1'b0;
    raw_mode = 1'b1;
    raw_req  = 5'b10000;
    raw_ft   = {FLIT_PAYLOAD, 12'b0};
    repeat (3) step();
    check_eq("err_payload_idle", o_err[0], 1'b1);
    raw_req = '0;
    raw_ft  = '0;
    repeat (2) step();
    check_eq("err_sticky", o_err[0], 1'b1);
    raw_mode = 1'b0;
    do_reset();
    repeat (5) begin
      cin_req[0] = 1'b1; cin_req[1] = 1'b1;
      step();
    end
    step();
    check_eq("err_overflow", o_err[0], 1'b1);
    check_eq("err_overflow_cred0", obs_cred[0], 4);
    check_eq("err_overflow_cred1", obs_cred[1], 2);
    do_reset();
    auto_cin[0] = 1'b1; auto_cin[1] = 1'b1;
    push_flit(0, FLIT_HEADER); push_flit(0, FLIT_HEADER); push_flit(0, FLIT_TAIL);
    run_drain("err_hdr", 30);
    check_eq("err_hdr_active", o_err[0], 1'b1);

    // Reset in the middle of a packet
    do_reset();
    auto_cin[0] = 1'b0; auto_cin[1] = 1'b0;
    push_pkt(0, 2);
    repeat (3) step();
    check_eq("rst_mid_pops", pops[0][0], 2);
    rst_next = 1'b0;
    step();
    check_eq("rst_mid_grant", o_gnt[0], '0);
    check_eq("rst_mid_rd", o_rd[0], '0);
    check_eq("rst_mid_cred", obs_cred[0], 4);
    for (int d = 0; d < 2; d++) for (int i = 0; i < N; i++) srcq[d][i].delete();
    step();
    rst_next = 1'b1;
    step();
    clear_log();
    auto_cin[0] = 1'b1; auto_cin[1] = 1'b1;
    push_pkt(3, 1);
    run_drain("rst_after", 30);
    check_eq("rst_after_grant_s", ord_at(0, 0), 5'b01000);
    check_eq("rst_after_pops_s", pops[0][3], 3);

    // Randomized traffic and credit returns
    do_reset();
    auto_cin[0] = 1'b0; auto_cin[1] = 1'b0;
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if (srcq[0][i].size() == 0 && srcq[1][i].size() == 0 && $urandom_range(0, 5) == 0)
          push_pkt(i, $urandom_range(0, 2));
      for (int d = 0; d < 2; d++)
        cin_req[d] = (m_cred[d] < cmax(d)) && ($urandom_range(0, 2) != 0);
      step();
    end
    auto_cin[0] = 1'b1; auto_cin[1] = 1'b1;
    run_drain("random", 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
